// File: rtl/image_load_ctrl.sv
// image_load_ctrl: streams N_ROWS slices into a row decoder, then holds the
// finished image until the consumer acknowledges it. It also counts images.
module image_load_ctrl #(
    parameter  int W      = 8,
    parameter  int N_ROWS = 8,
    localparam int SW     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          clr_i,
    input  logic [W-1:0]  s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [W-1:0]  dec_slice_o,
    output logic          dec_en_o,
    output logic [SW-1:0] dec_sel_o,
    output logic          img_valid_o,
    input  logic          img_ack_i,
    output logic          busy_o,
    output logic [15:0]   frame_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [SW-1:0] LAST_ROW = SW'(N_ROWS - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] dec_sel_q, dec_sel_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          accept;
    logic          ack;

    // Handshake decode; clr_i blocks any accept or ack in its cycle.
    always_comb begin
        s_ready_o   = (state_q == ST_LOAD) && !clr_i;
        accept      = s_valid_i && s_ready_o;
        dec_en_o    = accept;
        dec_slice_o = s_data_i;
        img_valid_o = (state_q == ST_DONE);
        ack         = img_ack_i && img_valid_o && !clr_i;
        busy_o      = (state_q != ST_IDLE);
        dec_sel_o   = dec_sel_q;
        frame_cnt_o = frame_cnt_q;
    end

    // Next-state, row counter, row select and frame counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dec_sel_d   = dec_sel_q;
        frame_cnt_d = frame_cnt_q;
        if (clr_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        dec_sel_d = cnt_q;
                        if (cnt_q == LAST_ROW) begin
                            cnt_d   = '0;
                            state_d = ST_SETTLE;
                        end else begin
                            cnt_d = cnt_q + SW'(1);
                        end
                    end
                end
                ST_SETTLE: state_d = ST_DONE;
                ST_DONE: begin
                    if (ack) begin
                        state_d     = ST_IDLE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dec_sel_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dec_sel_q   <= dec_sel_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_image_load_ctrl.sv
// Testbench for image_load_ctrl: directed scenarios plus random traffic
// checked against a transaction-level model of the load/settle/done protocol.
module tb_image_load_ctrl;

    localparam int W  = 8;
    localparam int NR = 8;
    localparam int SW = 3;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_DONE   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          clr_i = 1'b0;
    logic [W-1:0]  s_data_i = '0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [W-1:0]  dec_slice_o;
    logic          dec_en_o;
    logic [SW-1:0] dec_sel_o;
    logic          img_valid_o;
    logic          img_ack_i = 1'b0;
    logic          busy_o;
    logic [15:0]   frame_cnt_o;

    image_load_ctrl #(.W(W), .N_ROWS(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .clr_i       (clr_i),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .dec_slice_o (dec_slice_o),
        .dec_en_o    (dec_en_o),
        .dec_sel_o   (dec_sel_o),
        .img_valid_o (img_valid_o),
        .img_ack_i   (img_ack_i),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int          m_phase = P_IDLE;
    int          m_rows  = 0;
    int          m_sel   = 0;
    int          m_frame = 0;
    logic [W-1:0] m_img   [NR];
    // Decoder register bank as seen through dec_en_o / dec_sel_o.
    logic [W-1:0] dec_rows[NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_rows  = 0;
        m_sel   = 0;
        m_frame = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(s_ready_o), 0);
        check("rst_en", 32'(dec_en_o), 0);
        check("rst_sel", 32'(dec_sel_o), 0);
        check("rst_img", 32'(img_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_frame", 32'(frame_cnt_o), 0);
    endtask

    // One clock: inputs set by caller just after a negedge; returns at next negedge.
    task automatic cycle();
        bit         exp_ready, exp_en, acc;
        logic       pre_en;
        logic [W-1:0] pre_slice;
        bit         entered_done;
        #1;
        exp_ready = (m_phase == P_LOAD) && !clr_i;
        exp_en    = exp_ready && s_valid_i;
        check("s_ready", 32'(s_ready_o), 32'(exp_ready));
        check("dec_en", 32'(dec_en_o), 32'(exp_en));
        check("img_valid", 32'(img_valid_o), 32'(m_phase == P_DONE));
        check("busy", 32'(busy_o), 32'(m_phase != P_IDLE));
        if (exp_en) check("dec_slice", 32'(dec_slice_o), 32'(s_data_i));
        pre_en    = dec_en_o;
        pre_slice = dec_slice_o;
        acc       = exp_en;
        entered_done = 0;
        @(posedge clk);
        if (clr_i) begin
            m_phase = P_IDLE;
            m_rows  = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start_i) begin m_phase = P_LOAD; m_rows = 0; end
                P_LOAD: if (acc) begin
                    m_img[m_rows] = s_data_i;
                    m_sel = m_rows;
                    m_rows++;
                    if (m_rows == NR) begin m_rows = 0; m_phase = P_SETTLE; end
                end
                P_SETTLE: begin m_phase = P_DONE; entered_done = 1; end
                default: if (img_ack_i) begin
                    m_phase = P_IDLE;
                    m_frame = (m_frame + 1) % 65536;
                end
            endcase
        end
        #1;
        if (pre_en) dec_rows[dec_sel_o] = pre_slice;
        check("dec_sel", 32'(dec_sel_o), 32'(m_sel));
        check("frame_cnt", 32'(frame_cnt_o), 32'(m_frame));
        if (entered_done)
            for (int r = 0; r < NR; r++) check($sformatf("row%0d", r), 32'(dec_rows[r]), 32'(m_img[r]));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start_i = 0; clr_i = 0; s_valid_i = 0; img_ack_i = 0; s_data_i = '0;
    endtask

    // Start a load and push NR slices; stall=1 inserts an idle cycle before each slice.
    task automatic load_image(input logic [W-1:0] base, input bit stall, output int edges);
        idle_inputs();
        start_i = 1;
        cycle();
        edges = 1;
        start_i = 0;
        for (int r = 0; r < NR; r++) begin
            if (stall) begin
                s_valid_i = 0;
                cycle();
                edges++;
            end
            s_valid_i = 1;
            s_data_i  = W'(base * (r + 1));
            cycle();
            edges++;
        end
        s_valid_i = 0;
        for (int g = 0; g < 20 && !img_valid_o; g++) begin
            cycle();
            edges++;
        end
        check("img_ready_timeout", 32'(img_valid_o), 1);
    endtask

    task automatic ack_image();
        img_ack_i = 1;
        cycle();
        img_ack_i = 0;
    endtask

    initial begin
        int edges;
        for (int r = 0; r < NR; r++) begin dec_rows[r] = '0; m_img[r] = '0; end
        model_reset();
        #2;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // Back-to-back image 0x11..0x88 with minimum latency.
        load_image(8'h11, 0, edges);
        check("latency", 32'(edges), NR + 2);
        // Ack withheld for 5 cycles, then acknowledged.
        for (int i = 0; i < 5; i++) cycle();
        ack_image();
        check("frame_after_ack", 32'(frame_cnt_o), 1);

        // Same stream with valid toggling every other cycle.
        load_image(8'h11, 1, edges);
        check("latency_stall", 32'(edges), 2 * NR + 2);
        ack_image();

        // Abort with clr_i while four rows are loaded and valid is high.
        idle_inputs();
        start_i = 1; cycle(); start_i = 0;
        for (int r = 0; r < 4; r++) begin s_valid_i = 1; s_data_i = W'(8'hA0 + r); cycle(); end
        s_data_i = 8'hEE; clr_i = 1; cycle();
        clr_i = 0; s_valid_i = 0;
        check("clr_to_idle", 32'(busy_o), 0);
        cycle();
        load_image(8'h07, 0, edges);
        ack_image();

        // Stray ack in IDLE and stray start in LOAD have no effect.
        img_ack_i = 1; cycle(); cycle(); img_ack_i = 0;
        start_i = 1; cycle();
        s_valid_i = 1; s_data_i = 8'h5A; cycle();
        start_i = 0; s_valid_i = 0; cycle();
        clr_i = 1; cycle(); clr_i = 0;

        // Asynchronous reset while an image is pending in DONE.
        load_image(8'h23, 0, edges);
        #2 rst = 1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) cycle();

        // Frame counter wrap from 0xFFFF.
        force dut.frame_cnt_d = 16'hFFFF;
        m_frame = 16'hFFFF;
        cycle();
        release dut.frame_cnt_d;
        cycle();
        load_image(8'h31, 0, edges);
        ack_image();
        check("frame_wrap", 32'(frame_cnt_o), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            start_i   = ($urandom_range(0, 7) == 0);
            s_valid_i = $urandom_range(0, 1) == 1;
            s_data_i  = W'($urandom);
            img_ack_i = ($urandom_range(0, 3) == 0);
            clr_i     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench cannot hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
